alu_share_arbiter: RTL and testbench

//   Shares one alu instance between NREQ requesters. Each requester offers
//   (opcode, op1, op2) with a valid/ready handshake. The block grants one

---
 rtl/alu_share_arbiter.sv | 165 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_share_arbiter
//  Description : Round-robin sharing of a single ALU between NREQ requesters.
//                Grants one valid/ready request, holds the ALU operands,
//                waits ALU_LAT cycles, captures the result and returns it
//                tagged with the requester id. One operation in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int OPC_W   = 3,
    parameter int DATA_W  = 4,
    parameter int ALU_LAT = 1,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*OPC_W-1:0]  req_opcode,
    input  logic [NREQ*DATA_W-1:0] req_op1,
    input  logic [NREQ*DATA_W-1:0] req_op2,
    output logic [OPC_W-1:0]       alu_opcode,
    output logic [DATA_W-1:0]      alu_op1,
    output logic [DATA_W-1:0]      alu_op2,
    input  logic [DATA_W-1:0]      alu_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_data,
    output logic                   busy
);

    // Wait counter only has to hold ALU_LAT-1
    localparam int                CNT_W      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LOAD = CNT_W'(ALU_LAT - 1);
    localparam logic [ID_W-1:0]   C_LAST_ID  = ID_W'(NREQ - 1);
    localparam logic [ID_W:0]     C_NREQ     = (ID_W + 1)'(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [OPC_W-1:0]    r_alu_opcode;
    logic [DATA_W-1:0]   r_alu_op1;
    logic [DATA_W-1:0]   r_alu_op2;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_valid;
    logic                r_busy;

    logic [2*NREQ-1:0]   w_rot;
    logic                w_found;
    logic [ID_W-1:0]     w_grant;
    logic [ID_W:0]       w_sum;
    logic [NREQ-1:0]     w_req_ready;
    logic [OPC_W-1:0]    w_sel_opc;
    logic [DATA_W-1:0]   w_sel_op1;
    logic [DATA_W-1:0]   w_sel_op2;

    // Round-robin search: rotate the valid vector so bit 0 is requester rr_ptr
    always_comb begin
        w_rot   = {req_valid, req_valid} >> r_rr_ptr;
        w_found = 1'b0;
        w_grant = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (ID_W + 1)'(k);
                if (w_sum >= C_NREQ) begin
                    w_sum = w_sum - C_NREQ;
                end
                w_grant = w_sum[ID_W-1:0];
            end
        end
    end

    // One-hot ready toward the granted requester, only while idle, plus field mux
    always_comb begin
        w_req_ready = '0;
        w_sel_opc   = '0;
        w_sel_op1   = '0;
        w_sel_op2   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_req_ready[i] = rstn && (r_state == S_IDLE) && w_found;
                w_sel_opc      = req_opcode[i*OPC_W +: OPC_W];
                w_sel_op1      = req_op1[i*DATA_W +: DATA_W];
                w_sel_op2      = req_op2[i*DATA_W +: DATA_W];
            end
        end
    end

    // Control FSM: accept, drive ALU, wait for latency, hold response until taken
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rsp_id     <= '0;
            r_rsp_data   <= '0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_alu_opcode <= w_sel_opc;
                        r_alu_op1    <= w_sel_op1;
                        r_alu_op2    <= w_sel_op2;
                        r_rsp_id     <= w_grant;
                        r_rr_ptr     <= (w_grant == C_LAST_ID) ? '0 : w_grant + 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= C_CNT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_cnt == '0) begin
                        r_rsp_data  <= alu_result;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = w_req_ready;
    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_data   = r_rsp_data;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_share_arbiter
//  Description : Self-checking bench for alu_share_arbiter with an adder ALU
//                stub and a transaction-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;

    localparam int NREQ    = 4;
    localparam int OPC_W   = 3;
    localparam int DATA_W  = 4;
    localparam int ALU_LAT = 1;
    localparam int ID_W    = 2;
    localparam int RSP_AGE = 2 + ALU_LAT;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b1;
    logic [NREQ-1:0]        req_valid = '0;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*OPC_W-1:0]  req_opcode = '0;
    logic [NREQ*DATA_W-1:0] req_op1 = '0;
    logic [NREQ*DATA_W-1:0] req_op2 = '0;
    logic [OPC_W-1:0]       alu_opcode;
    logic [DATA_W-1:0]      alu_op1;
    logic [DATA_W-1:0]      alu_op2;
    logic [DATA_W-1:0]      alu_result;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [ID_W-1:0]        rsp_id;
    logic [DATA_W-1:0]      rsp_data;
    logic                   busy;

    always #5 clk = ~clk;

    // ALU stub: 4-bit adder
    assign alu_result = alu_op1 + alu_op2;

    alu_share_arbiter #(
        .NREQ(NREQ), .OPC_W(OPC_W), .DATA_W(DATA_W), .ALU_LAT(ALU_LAT), .ID_W(ID_W)
    ) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
        .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one transaction, age counted in cycles since the accept cycle
    bit m_inflight;
    int m_age, m_ptr, m_rsp_id, m_rsp_data, m_result;
    int m_opc, m_op1, m_op2;
    bit m_acc;
    int cyc = 0;
    int grants[$];
    int acc_cyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_age = 0; m_ptr = 0; m_rsp_id = 0; m_rsp_data = 0;
        m_result = 0; m_opc = 0; m_op1 = 0; m_op2 = 0; m_acc = 0;
    endtask

    task automatic check_outputs();
        logic [NREQ-1:0] er;
        int g;
        er = '0;
        if (rstn && !m_inflight) begin
            g = model_grant(req_valid, m_ptr);
            if (g >= 0) er[g] = 1'b1;
        end
        check("req_ready",  32'(req_ready),  32'(er));
        check("busy",       32'(busy),       32'(m_inflight));
        check("rsp_valid",  32'(rsp_valid),  32'(m_inflight && m_age >= RSP_AGE));
        check("rsp_id",     32'(rsp_id),     m_rsp_id);
        check("rsp_data",   32'(rsp_data),   m_rsp_data);
        check("alu_opcode", 32'(alu_opcode), m_opc);
        check("alu_op1",    32'(alu_op1),    m_op1);
        check("alu_op2",    32'(alu_op2),    m_op2);
    endtask

    // One clock: check outputs mid-cycle, advance model across the edge
    task automatic step();
        int  g;
        bit  rv, rr;
        int  f_opc, f_op1, f_op2;
        #1;
        check_outputs();
        g  = m_inflight ? -1 : model_grant(req_valid, m_ptr);
        rv = m_inflight && (m_age >= RSP_AGE);
        rr = rsp_ready;
        f_opc = 0; f_op1 = 0; f_op2 = 0;
        if (g >= 0) begin
            f_opc = int'(req_opcode[g*OPC_W +: OPC_W]);
            f_op1 = int'(req_op1[g*DATA_W +: DATA_W]);
            f_op2 = int'(req_op2[g*DATA_W +: DATA_W]);
        end
        @(posedge clk);
        cyc++;
        m_acc = 0;
        if (m_inflight) begin
            if (rv && rr) begin
                m_inflight = 0;
            end else begin
                m_age++;
                if (m_age == RSP_AGE) m_rsp_data = m_result;
            end
        end else if (g >= 0) begin
            m_inflight = 1; m_age = 1; m_acc = 1;
            m_rsp_id = g; m_opc = f_opc; m_op1 = f_op1; m_op2 = f_op2;
            m_result = (f_op1 + f_op2) % 16;
            m_ptr = (g + 1) % NREQ;
            grants.push_back(g);
            acc_cyc.push_back(cyc);
        end
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic set_req(input int i, input int opc, input int a, input int b, input bit v);
        req_opcode[i*OPC_W +: OPC_W] = OPC_W'(opc);
        req_op1[i*DATA_W +: DATA_W]  = DATA_W'(a);
        req_op2[i*DATA_W +: DATA_W]  = DATA_W'(b);
        req_valid[i]                 = v;
    endtask

    task automatic rand_req(input int i, input bit v);
        set_req(i, int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                int'($urandom_range(0, 15)), v);
    endtask

    task automatic run_until_idle();
        int n;
        n = 0;
        while (m_inflight && n < 30) begin
            step();
            n++;
        end
        if (m_inflight) check("idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        // Reset state
        do_reset();

        // T1: single request from requester 0
        rsp_ready = 1'b1;
        set_req(0, 1, 3, 5, 1);
        step();
        check("t1_alu_op1", 32'(alu_op1), 32'd3);
        check("t1_alu_op2", 32'(alu_op2), 32'd5);
        set_req(0, 0, 0, 0, 0);
        step();
        step();
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_rsp_id",    32'(rsp_id),    32'd0);
        check("t1_rsp_data",  32'(rsp_data),  32'd8);
        run_until_idle();
        step();

        // T2: all requesters valid continuously, fresh pointer
        do_reset();
        grants.delete();
        acc_cyc.delete();
        for (int i = 0; i < NREQ; i++) rand_req(i, 1);
        n = 0;
        while (grants.size() < 5 && n < 60) begin
            step();
            if (m_acc) rand_req(grants[$], 1);
            n++;
        end
        check("t2_accepts", 32'(grants.size()), 32'd5);
        for (int i = 0; i < grants.size(); i++) check("t2_order", 32'(grants[i]), 32'(i % NREQ));
        for (int i = 1; i < acc_cyc.size(); i++)
            check("t2_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(ALU_LAT + 3));
        req_valid = '0;
        run_until_idle();

        // T3: response stall with other requesters pending
        rsp_ready = 1'b0;
        rand_req(2, 1);
        step();
        req_valid = '0;
        n = 0;
        while (!(m_inflight && m_age >= RSP_AGE) && n < 10) begin
            step();
            n++;
        end
        check("t3_reached_resp", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < NREQ; i++) rand_req(i, 1);
        for (int i = 0; i < 10; i++) step();
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        check("t3_idle_after", 32'(busy), 32'd0);

        // T4: lone requester 3 granted back to back, result wraps
        set_req(3, 2, 15, 1, 1);
        step();
        req_valid = '0;
        run_until_idle();
        set_req(3, 2, 15, 1, 1);
        step();
        check("t4_regrant_id", 32'(rsp_id), 32'd3);
        req_valid = '0;
        step();
        step();
        check("t4_wrap_data", 32'(rsp_data), 32'd0);
        run_until_idle();

        // T5: reset during WAIT, then grant search restarts at 0
        rand_req(2, 1);
        step();
        req_valid = '0;
        step();
        do_reset();
        for (int i = 0; i < 6; i++) step();
        rand_req(1, 1);
        rand_req(3, 1);
        step();
        check("t5_ptr_restart", 32'(rsp_id), 32'd1);
        req_valid = '0;
        run_until_idle();

        // T6: short-lived request while busy is withdrawn without effect
        rand_req(0, 1);
        step();
        req_valid = '0;
        rand_req(1, 1);
        step();
        req_valid = '0;
        run_until_idle();
        for (int i = 0; i < 5; i++) step();
        check("t6_not_busy", 32'(busy), 32'd0);

        // Random traffic with withdrawals and back-pressure
        for (int i = 0; i < 400; i++) begin
            for (int r = 0; r < NREQ; r++) rand_req(r, 1'($urandom_range(0, 1)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        run_until_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
